img_stream_sequencer: RTL and testbench

Frame-timing controller that drives the 3x3 matrix generator / median-filter pipeline from a buffered 8-bit pixel source. It pulls pixels over a valid/ready handshake and emits per_img_vsync / per_img_href / per_img_gray with gap-free lines, enforced horizontal blanking, and a frame tail. The tail keeps vsync high until the generator's synthesized bottom row has fully drained, so back-to-back frames never overlap it. It also provides start/busy/frame_done control and an underflow flag.

---
 rtl/img_stream_sequencer.sv | 161 ++++++++++++++++
 tb/tb_img_stream_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_stream_sequencer.sv
// Frame-timing controller: pulls buffered pixels over valid/ready and drives the
// vsync/href/gray timing expected by the 3x3 matrix generator / median-filter pipeline.
module img_stream_sequencer #(
   parameter int IMG_HDISP = 640,
   parameter int IMG_VDISP = 480,
   parameter int DELAY_NUM = 10,
   parameter int H_BLANK   = 16,
   parameter int V_FRONT   = 4,
   parameter int V_BACK    = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       continuous,
   input  logic       s_valid,
   input  logic [7:0] s_data,
   input  logic       s_line_avail,
   output logic       s_ready,
   output logic       per_img_vsync,
   output logic       per_img_href,
   output logic [7:0] per_img_gray,
   output logic       busy,
   output logic       frame_done,
   output logic       underflow
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_VFRONT,
      S_WAITL,
      S_LINE,
      S_HBLANK,
      S_TAIL,
      S_VBACK
   } state_t;

   // Tail covers the generator's synthesized bottom row plus its 2-cycle output pipeline.
   localparam int          TAIL_LEN = DELAY_NUM + IMG_HDISP + 4;
   localparam logic [10:0] H_LAST   = 11'(IMG_HDISP - 1);
   localparam logic [10:0] V_LAST   = 11'(IMG_VDISP - 1);
   localparam logic [11:0] VF_LAST  = 12'(V_FRONT - 1);
   localparam logic [11:0] HB_LAST  = 12'(H_BLANK - 1);
   localparam logic [11:0] TL_LAST  = 12'(TAIL_LEN - 1);
   localparam logic [11:0] VB_LAST  = 12'(V_BACK - 1);

   state_t      state, state_nxt;
   logic [10:0] hcnt, hcnt_nxt;
   logic [10:0] vcnt, vcnt_nxt;
   logic [11:0] cnt, cnt_nxt;
   logic        done_nxt;
   logic        in_frame;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_nxt = state;
      hcnt_nxt  = hcnt;
      vcnt_nxt  = vcnt;
      cnt_nxt   = cnt;
      done_nxt  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_VFRONT;
               cnt_nxt   = '0;
               vcnt_nxt  = '0;
            end
         end
         S_VFRONT, S_HBLANK: begin
            // A line already buffered skips WAITL, so back-to-back lines cost no extra cycle.
            if ((state == S_VFRONT && cnt == VF_LAST) || (state == S_HBLANK && cnt == HB_LAST)) begin
               cnt_nxt   = '0;
               hcnt_nxt  = '0;
               state_nxt = s_line_avail ? S_LINE : S_WAITL;
            end else begin
               cnt_nxt = cnt + 12'd1;
            end
         end
         S_WAITL: begin
            if (s_line_avail) begin
               state_nxt = S_LINE;
               hcnt_nxt  = '0;
            end
         end
         S_LINE: begin
            if (hcnt == H_LAST) begin
               hcnt_nxt = '0;
               cnt_nxt  = '0;
               if (vcnt == V_LAST) begin
                  state_nxt = S_TAIL;
               end else begin
                  vcnt_nxt  = vcnt + 11'd1;
                  state_nxt = S_HBLANK;
               end
            end else begin
               hcnt_nxt = hcnt + 11'd1;
            end
         end
         S_TAIL: begin
            if (cnt == TL_LAST) begin
               cnt_nxt   = '0;
               state_nxt = S_VBACK;
            end else begin
               cnt_nxt = cnt + 12'd1;
            end
         end
         S_VBACK: begin
            if (cnt == VB_LAST) begin
               cnt_nxt  = '0;
               done_nxt = 1'b1;
               if (continuous) begin
                  state_nxt = S_VFRONT;
                  vcnt_nxt  = '0;
               end else begin
                  state_nxt = S_IDLE;
               end
            end else begin
               cnt_nxt = cnt + 12'd1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign s_ready  = (state == S_LINE);
   assign in_frame = (state == S_VFRONT) || (state == S_WAITL) || (state == S_LINE) ||
                     (state == S_HBLANK) || (state == S_TAIL);

   // Every output is registered from the current state, so vsync, href and gray all
   // lag the state by one cycle and keep their mutual alignment.
   // NOTE: sequential state uses non-blocking assignments so each register sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         hcnt          <= '0;
         vcnt          <= '0;
         cnt           <= '0;
         per_img_vsync <= 1'b0;
         per_img_href  <= 1'b0;
         per_img_gray  <= 8'h00;
         busy          <= 1'b0;
         frame_done    <= 1'b0;
         underflow     <= 1'b0;
      end else begin
         state         <= state_nxt;
         hcnt          <= hcnt_nxt;
         vcnt          <= vcnt_nxt;
         cnt           <= cnt_nxt;
         per_img_vsync <= in_frame;
         per_img_href  <= (state == S_LINE);
         per_img_gray  <= (state == S_LINE && s_valid) ? s_data : 8'h00;
         busy          <= (state != S_IDLE);
         frame_done    <= done_nxt;
         if (state == S_IDLE && start) begin
            underflow <= 1'b0;
         end else if (state == S_LINE && !s_valid) begin
            underflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_img_stream_sequencer.sv
// Self-checking bench for img_stream_sequencer: records output streams per scenario and
// compares frame/line/pixel timing and data against a model derived from the frame rules.
module tb_img_stream_sequencer;

   localparam int HD        = 8;
   localparam int VD        = 4;
   localparam int HB        = 3;
   localparam int VF        = 2;
   localparam int VB        = 2;
   localparam int DN        = 2;
   localparam int TL        = DN + HD + 4;
   localparam int FRAME_PIX = HD * VD;
   localparam int GAP_EXTRA = 20;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       continuous = 1'b0;
   logic       s_valid = 1'b0;
   logic [7:0] s_data = 8'h00;
   logic       s_line_avail = 1'b0;
   logic       s_ready;
   logic       per_img_vsync;
   logic       per_img_href;
   logic [7:0] per_img_gray;
   logic       busy;
   logic       frame_done;
   logic       underflow;

   always #5 clk = ~clk;

   img_stream_sequencer #(
      .IMG_HDISP (HD),
      .IMG_VDISP (VD),
      .DELAY_NUM (DN),
      .H_BLANK   (HB),
      .V_FRONT   (VF),
      .V_BACK    (VB)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .continuous    (continuous),
      .s_valid       (s_valid),
      .s_data        (s_data),
      .s_line_avail  (s_line_avail),
      .s_ready       (s_ready),
      .per_img_vsync (per_img_vsync),
      .per_img_href  (per_img_href),
      .per_img_gray  (per_img_gray),
      .busy          (busy),
      .frame_done    (frame_done),
      .underflow     (underflow)
   );

   typedef struct packed {
      logic       vs;
      logic       hr;
      logic [7:0] gray;
      logic       fd;
      logic       busy;
      logic       uf;
   } sample_t;

   sample_t    rec[$];
   logic [7:0] px[0:255];
   bit         drop[0:255];
   int         slot, src_idx, post, gap_slot, done_cnt, n_target;
   bit         noise_en, cont_req;
   int         n_checks = 0;
   int         n_fail = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Source model: a buffered FIFO presenting px[] in order, valid pattern from drop[].
   task automatic drive_inputs();
      s_data       = px[src_idx % 256];
      s_valid      = !drop[slot];
      s_line_avail = !(slot == gap_slot && post >= 2 && post < 2 + GAP_EXTRA);
      start        = noise_en && ((slot == 10 && post == 0) || (slot == FRAME_PIX && post == 5));
      continuous   = cont_req && (done_cnt < n_target - 1);
   endtask

   task automatic cycle();
      sample_t s;
      logic    rdy, vld;
      @(negedge clk);
      s.vs   = per_img_vsync;
      s.hr   = per_img_href;
      s.gray = per_img_gray;
      s.fd   = frame_done;
      s.busy = busy;
      s.uf   = underflow;
      rec.push_back(s);
      if (frame_done) done_cnt++;
      rdy = s_ready;
      vld = s_valid;
      @(posedge clk);
      #1;
      if (rdy) begin
         if (vld) src_idx++;
         slot++;
         post = 0;
      end else begin
         post++;
      end
      drive_inputs();
   endtask

   task automatic clear_drops();
      for (int i = 0; i < 256; i++) drop[i] = 1'b0;
   endtask

   task automatic random_pixels();
      for (int i = 0; i < 256; i++) px[i] = 8'($urandom_range(0, 255));
   endtask

   task automatic begin_scn(input int nf, input bit cont, input int gap, input bit noise);
      rec.delete();
      slot     = 0;
      src_idx  = 0;
      post     = 0;
      done_cnt = 0;
      n_target = nf;
      cont_req = cont;
      gap_slot = gap;
      noise_en = noise;
      drive_inputs();
      start = 1'b1;
      cycle();
      check("uflow_clear_on_start", 32'(underflow), 0);
   endtask

   task automatic run_scn(input int nf, input bit cont, input int gap, input bit noise);
      begin_scn(nf, cont, gap, noise);
      for (int c = 0; c < 2000 && done_cnt < nf; c++) cycle();
      check("frames_within_budget", done_cnt, nf);
      repeat (3) cycle();
   endtask

   // Reference: extract vsync/href runs, pixel stream and done pulses, compare with frame rules.
   task automatic analyze(input int nf, input int gap_line);
      int vr[$], vl[$], hrr[$], hrl[$], fdi[$], gq[$], eq[$];
      int viol, k, exp_len;
      bit exp_uf;
      viol = 0;
      for (int i = 0; i < rec.size(); i++) begin
         if (rec[i].vs && (i == 0 || !rec[i-1].vs)) begin vr.push_back(i); vl.push_back(0); end
         if (rec[i].vs) vl[vl.size()-1]++;
         if (rec[i].hr && (i == 0 || !rec[i-1].hr)) begin hrr.push_back(i); hrl.push_back(0); end
         if (rec[i].hr) begin hrl[hrl.size()-1]++; gq.push_back(int'(rec[i].gray)); end
         if (rec[i].fd) fdi.push_back(i);
         if (rec[i].hr && !rec[i].vs) viol++;
         if (!rec[i].hr && rec[i].gray != 8'h00) viol++;
         if (rec[i].vs && !rec[i].busy) viol++;
      end
      check("vsync_frame_count", vr.size(), nf);
      for (int f = 0; f < nf && f < vr.size(); f++) begin
         exp_len = VF + FRAME_PIX + (VD - 1) * HB + TL + ((gap_line >= 0) ? GAP_EXTRA : 0);
         check("vsync_high_len", vl[f], exp_len);
         if (f * VD < hrr.size()) check("first_href_lead", hrr[f*VD] - vr[f], VF);
         if (f + 1 < vr.size()) check("vsync_low_between", vr[f+1] - vr[f] - vl[f], VB);
         if (f < fdi.size()) check("frame_done_pos", fdi[f] - (vr[f] + vl[f]), VB - 1);
      end
      check("href_count", hrr.size(), nf * VD);
      for (int i = 0; i < hrr.size(); i++) begin
         check("href_len", hrl[i], HD);
         if (i + 1 < hrr.size() && ((i + 1) % VD) != 0)
            check("href_gap", hrr[i+1] - hrr[i] - hrl[i], HB + (((i % VD) == gap_line) ? GAP_EXTRA : 0));
      end
      k = 0;
      exp_uf = 1'b0;
      for (int s = 0; s < nf * FRAME_PIX; s++) begin
         if (drop[s]) begin
            eq.push_back(0);
            exp_uf = 1'b1;
         end else begin
            eq.push_back(int'(px[k]));
            k++;
         end
      end
      check("gray_count", gq.size(), eq.size());
      for (int j = 0; j < gq.size() && j < eq.size(); j++) check("gray_value", gq[j], eq[j]);
      check("frame_done_count", fdi.size(), nf);
      check("protocol_violations", viol, 0);
      check("busy_at_end", 32'(rec[rec.size()-1].busy), 0);
      check("underflow_at_end", 32'(rec[rec.size()-1].uf), 32'(exp_uf));
   endtask

   initial begin
      for (int i = 0; i < 256; i++) px[i] = 8'(i);
      clear_drops();
      gap_slot = -1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_vsync", 32'(per_img_vsync), 0);
      check("rst_href", 32'(per_img_href), 0);
      check("rst_gray", 32'(per_img_gray), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(frame_done), 0);
      check("rst_uflow", 32'(underflow), 0);
      check("rst_ready", 32'(s_ready), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("idle_busy", 32'(busy), 0);

      // 1: single frame, incrementing data.
      run_scn(1, 1'b0, -1, 1'b0);
      analyze(1, -1);

      // 2: line not available for 20 cycles before the third line.
      random_pixels();
      run_scn(1, 1'b0, 2 * HD, 1'b0);
      analyze(1, 1);

      // 3: dropped pixel 5 of line 1; underflow stays set while idle.
      random_pixels();
      drop[HD + 5] = 1'b1;
      run_scn(1, 1'b0, -1, 1'b0);
      analyze(1, -1);
      repeat (5) cycle();
      check("uflow_sticky_idle", 32'(underflow), 1);
      clear_drops();

      // 4: three continuous frames (start clears the sticky underflow).
      random_pixels();
      run_scn(3, 1'b1, -1, 1'b0);
      analyze(3, -1);

      // 5: spurious start pulses during LINE and TAIL.
      random_pixels();
      run_scn(1, 1'b0, -1, 1'b1);
      analyze(1, -1);

      // 6: asynchronous reset mid-line 2, then a clean frame.
      random_pixels();
      begin_scn(1, 1'b0, -1, 1'b0);
      for (int c = 0; c < 200 && slot < HD + 4; c++) cycle();
      check("pre_reset_href", 32'(per_img_href), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_vsync", 32'(per_img_vsync), 0);
      check("async_rst_href", 32'(per_img_href), 0);
      check("async_rst_gray", 32'(per_img_gray), 0);
      check("async_rst_busy", 32'(busy), 0);
      check("async_rst_ready", 32'(s_ready), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_busy", 32'(busy), 0);
      random_pixels();
      run_scn(1, 1'b0, -1, 1'b0);
      analyze(1, -1);

      // 7: random data with random pixel drops.
      random_pixels();
      for (int i = 0; i < FRAME_PIX; i++) drop[i] = ($urandom_range(0, 7) == 0);
      drop[3] = 1'b1;
      run_scn(1, 1'b0, -1, 1'b0);
      analyze(1, -1);
      clear_drops();

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
